// File: rtl/fcl_pair_acc.sv
// Signed pair accumulator for one FC neuron: bias + sum of NUM_PAIRS operand pairs,
// saturated to INPUT_WIDTH. Optional macro FCL_PAIR_ACC_RELU_EN zeroes negative results.
module fcl_pair_acc #(
  parameter int INPUT_WIDTH = 32,
  parameter int PAIR_WIDTH  = 2*INPUT_WIDTH,
  parameter int ACC_WIDTH   = 48,
  parameter int NUM_PAIRS   = 200
) (
  input  logic                   fcl_pair_acc_clk,
  input  logic                   fcl_pair_acc_rst_b,
  input  logic                   fcl_pair_acc_start_i,
  input  logic [INPUT_WIDTH-1:0] fcl_pair_acc_bias_i,
  input  logic                   fcl_pair_acc_en_i,
  input  logic [PAIR_WIDTH-1:0]  fcl_pair_acc_pair_i,
  input  logic                   fcl_pair_acc_clr_i,
  output logic                   fcl_pair_acc_busy_o,
  output logic                   fcl_pair_acc_done_o,
  output logic [INPUT_WIDTH-1:0] fcl_pair_acc_sum_o,
  output logic                   fcl_pair_acc_ovf_o
);

  localparam int CNT_W = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_PAIRS - 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-INPUT_WIDTH+1){1'b0}}, {(INPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-INPUT_WIDTH+1){1'b1}}, {(INPUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACC, FINAL} state_e;

  state_e                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [INPUT_WIDTH-1:0]        sum_q, sum_d;
  logic                          ovf_q, ovf_d;
  logic                          done_pend_q, done_pend_d;
  logic                          done_q, done_d;

  logic [INPUT_WIDTH-1:0]        op_lo, op_hi;
  logic signed [ACC_WIDTH-1:0]   bias_ext, lo_ext, hi_ext;
  logic [INPUT_WIDTH-1:0]        res;
  logic                          res_ovf;

  assign op_lo    = fcl_pair_acc_pair_i[INPUT_WIDTH-1:0];
  assign op_hi    = fcl_pair_acc_pair_i[2*INPUT_WIDTH-1:INPUT_WIDTH];
  assign bias_ext = {{(ACC_WIDTH-INPUT_WIDTH){fcl_pair_acc_bias_i[INPUT_WIDTH-1]}}, fcl_pair_acc_bias_i};
  assign lo_ext   = {{(ACC_WIDTH-INPUT_WIDTH){op_lo[INPUT_WIDTH-1]}}, op_lo};
  assign hi_ext   = {{(ACC_WIDTH-INPUT_WIDTH){op_hi[INPUT_WIDTH-1]}}, op_hi};

  always_comb begin
    res     = acc_q[INPUT_WIDTH-1:0];
    res_ovf = 1'b0;
    if (acc_q > SAT_MAX) begin
      res     = {1'b0, {(INPUT_WIDTH-1){1'b1}}};
      res_ovf = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      res     = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
      res_ovf = 1'b1;
    end
`ifdef FCL_PAIR_ACC_RELU_EN
    if (res[INPUT_WIDTH-1]) res = '0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    done_pend_d = 1'b0;
    done_d      = done_pend_q;
    if (fcl_pair_acc_clr_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fcl_pair_acc_start_i) begin
            acc_d   = bias_ext;
            cnt_d   = '0;
            state_d = ACC;
          end
        end
        ACC: begin
          if (fcl_pair_acc_en_i) begin
            acc_d = acc_q + lo_ext + hi_ext;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) state_d = FINAL;
          end
        end
        FINAL: begin
          // Result registers here; done follows one edge later so sum is already stable.
          sum_d       = res;
          ovf_d       = res_ovf;
          done_pend_d = 1'b1;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge fcl_pair_acc_clk or negedge fcl_pair_acc_rst_b) begin
    if (!fcl_pair_acc_rst_b) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      done_pend_q <= done_pend_d;
      done_q      <= done_d;
    end
  end

  assign fcl_pair_acc_busy_o = (state_q != IDLE);
  assign fcl_pair_acc_done_o = done_q;
  assign fcl_pair_acc_sum_o  = sum_q;
  assign fcl_pair_acc_ovf_o  = ovf_q;

endmodule

// File: tb/tb_fcl_pair_acc.sv
// Self-checking bench for fcl_pair_acc (NUM_PAIRS=4): directed and random neurons
// against an arithmetic reference model.
module tb_fcl_pair_acc;

  localparam int IW = 32;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst_n, start, en, clr;
  logic [IW-1:0] bias;
  logic [2*IW-1:0] pair;
  logic          busy, done, ovf;
  logic [IW-1:0] sum;

  int n_cmp = 0;
  int n_err = 0;
  logic [IW-1:0] exp_sum = '0;
  logic          exp_ovf = 1'b0;

  fcl_pair_acc #(
    .INPUT_WIDTH(IW),
    .PAIR_WIDTH (2*IW),
    .ACC_WIDTH  (48),
    .NUM_PAIRS  (NP)
  ) dut (
    .fcl_pair_acc_clk    (clk),
    .fcl_pair_acc_rst_b  (rst_n),
    .fcl_pair_acc_start_i(start),
    .fcl_pair_acc_bias_i (bias),
    .fcl_pair_acc_en_i   (en),
    .fcl_pair_acc_pair_i (pair),
    .fcl_pair_acc_clr_i  (clr),
    .fcl_pair_acc_busy_o (busy),
    .fcl_pair_acc_done_o (done),
    .fcl_pair_acc_sum_o  (sum),
    .fcl_pair_acc_ovf_o  (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input int b, input int a[NP], input int c[NP],
                                output logic [IW-1:0] s, output logic o);
    longint t;
    t = longint'(b);
    for (int i = 0; i < NP; i++) t += longint'(a[i]) + longint'(c[i]);
    o = 1'b0;
    if (t > 64'sd2147483647) begin
      t = 64'sd2147483647; o = 1'b1;
    end else if (t < -64'sd2147483648) begin
      t = -64'sd2147483648; o = 1'b1;
    end
`ifdef FCL_PAIR_ACC_RELU_EN
    if (t < 0) t = 0;
`endif
    s = t[IW-1:0];
  endfunction

  task automatic feed_pairs(input string tag, input int a[NP], input int c[NP],
                            input int n, input int mingap, input int maxgap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(mingap, maxgap);
      repeat (g) begin
        start = 1'($urandom_range(0, 1));  // ignored outside IDLE
        en = 1'b0;
        tick();
        start = 1'b0;
        check({tag, "/gap_busy"}, 64'(busy), 64'(1));
        check({tag, "/gap_done"}, 64'(done), 64'(0));
        check({tag, "/gap_hold"}, 64'(sum), 64'(exp_sum));
      end
      pair = {c[i], a[i]};
      en   = 1'b1;
      tick();
      en   = 1'b0;
    end
  endtask

  task automatic begin_neuron(input string tag, input int b);
    start = 1'b1;
    bias  = b;
    en    = 1'b1;                       // pair offered with start is discarded
    pair  = {32'($urandom), 32'($urandom)};
    tick();
    start = 1'b0;
    en    = 1'b0;
    check({tag, "/busy"}, 64'(busy), 64'(1));
  endtask

  task automatic run_neuron(input string tag, input int b, input int a[NP], input int c[NP],
                            input int mingap, input int maxgap);
    logic [IW-1:0] es;
    logic          eo;
    model(b, a, c, es, eo);
    begin_neuron(tag, b);
    feed_pairs(tag, a, c, NP, mingap, maxgap);
    check({tag, "/done_k"}, 64'(done), 64'(0));
    check({tag, "/busy_final"}, 64'(busy), 64'(1));
    tick();
    check({tag, "/done_k1"}, 64'(done), 64'(0));
    tick();
    check({tag, "/done_k2"}, 64'(done), 64'(1));
    check({tag, "/sum"}, 64'(sum), 64'(es));
    check({tag, "/ovf"}, 64'(ovf), 64'(eo));
    exp_sum = es;
    exp_ovf = eo;
    tick();
    check({tag, "/done_k3"}, 64'(done), 64'(0));
    check({tag, "/sum_hold"}, 64'(sum), 64'(exp_sum));
    check({tag, "/ovf_hold"}, 64'(ovf), 64'(exp_ovf));
  endtask

  initial begin
    int a[NP];
    int c[NP];
    rst_n = 1'b0; start = 1'b0; en = 1'b0; clr = 1'b0; bias = '0; pair = '0;
    #1;
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/done", 64'(done), 64'(0));
    check("rst/sum",  64'(sum),  64'(0));
    check("rst/ovf",  64'(ovf),  64'(0));
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // en while idle must not start anything
    en = 1'b1; pair = {32'd5, 32'd5}; tick(); en = 1'b0;
    check("idle_en/busy", 64'(busy), 64'(0));

    a = '{1, 3, 5, 7}; c = '{2, 4, 6, 8};
    run_neuron("b2b", 10, a, c, 0, 0);
    run_neuron("gaps", 10, a, c, 1, 3);

    a = '{-100, -100, -100, -100}; c = a;
    run_neuron("neg", 0, a, c, 0, 2);

    a = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}; c = a;
    run_neuron("satp", 0, a, c, 0, 1);

    a = '{int'(32'h80000000), int'(32'h80000000), 0, 0}; c = a;
    run_neuron("satn", -1, a, c, 0, 0);

    // abort after two pairs; clr beats start and en
    a = '{1000, 2000, 0, 0}; c = a;
    begin_neuron("clr", 7);
    feed_pairs("clr", a, c, 2, 0, 1);
    clr = 1'b1; start = 1'b1; en = 1'b1; tick();
    clr = 1'b0; start = 1'b0; en = 1'b0;
    check("clr/busy", 64'(busy), 64'(0));
    repeat (4) begin
      tick();
      check("clr/done", 64'(done), 64'(0));
      check("clr/sum_hold", 64'(sum), 64'(exp_sum));
      check("clr/ovf_hold", 64'(ovf), 64'(exp_ovf));
    end
    a = '{11, 22, 33, 44}; c = '{-1, -2, -3, -4};
    run_neuron("after_clr", 5, a, c, 0, 1);

    // abort in the FINAL cycle: no done, result not updated
    a = '{500, 500, 500, 500}; c = a;
    begin_neuron("clrfin", 1);
    feed_pairs("clrfin", a, c, NP, 0, 0);
    check("clrfin/busy", 64'(busy), 64'(1));
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (3) begin
      tick();
      check("clrfin/done", 64'(done), 64'(0));
      check("clrfin/sum_hold", 64'(sum), 64'(exp_sum));
      check("clrfin/busy", 64'(busy), 64'(0));
    end

    // asynchronous reset mid-accumulation
    a = '{9, 9, 0, 0}; c = a;
    begin_neuron("rst", 100);
    feed_pairs("rst", a, c, 2, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst/busy", 64'(busy), 64'(0));
    check("midrst/done", 64'(done), 64'(0));
    check("midrst/sum",  64'(sum),  64'(0));
    check("midrst/ovf",  64'(ovf),  64'(0));
    exp_sum = '0; exp_ovf = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    a = '{4, 3, 2, 1}; c = '{-10, 20, -30, 40};
    run_neuron("after_rst", -3, a, c, 0, 2);

    for (int n = 0; n < 24; n++) begin
      int b;
      bool_mode: begin
        if ($urandom_range(0, 2) == 0) begin
          b = int'($urandom);
          for (int i = 0; i < NP; i++) begin
            a[i] = int'($urandom);
            c[i] = int'($urandom);
          end
        end else begin
          b = int'($urandom_range(0, 4000)) - 2000;
          for (int i = 0; i < NP; i++) begin
            a[i] = int'($urandom_range(0, 2000000)) - 1000000;
            c[i] = int'($urandom_range(0, 2000000)) - 1000000;
          end
        end
      end
      run_neuron("rand", b, a, c, 0, 3);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
